// File: rtl/line_buf_ctrl_pkg.sv
// line_buf_ctrl_pkg: shared constants and state types for the ping-pong line buffer sequencer.
package line_buf_ctrl_pkg;

  localparam int unsigned PIX_IN_ROW         = 640;
  localparam int unsigned NUMB_CHAN          = 4;
  localparam int unsigned LB_ADDR_W          = 9;
  localparam int unsigned LB_LINE_W          = 9;
  localparam int unsigned LB_LINES_PER_FRAME = 240;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_HOLD = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/line_buf_ctrl_rd_seq.sv
// line_buf_rd_seq: read-side sequencer. Picks the waiting full bank, streams its
// addresses under RD_READY flow control and produces the output-valid and line/frame pulses.
module line_buf_rd_seq
  import line_buf_ctrl_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE    = PIX_IN_ROW / NUMB_CHAN,
  parameter int unsigned LINES_PER_FRAME = LB_LINES_PER_FRAME,
  parameter int unsigned ADDR_W          = LB_ADDR_W,
  parameter int unsigned LINE_W          = LB_LINE_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   rd_ready,
  input  logic [1:0]             bank_full,
  input  logic [1:0][LINE_W-1:0] bank_line,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_bank,
  output logic                   data_valid,
  output logic [LINE_W-1:0]      line_idx,
  output logic                   line_done,
  output logic                   frame_done,
  output logic                   rd_free
);

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] rd_cnt;
  logic              pick;

  // Strobe and address follow the registered state; the last strobe frees the bank.
  assign rd_en   = (rd_state == R_RUN) & rd_ready;
  assign rd_addr = rd_cnt;
  assign rd_free = rd_en & (rd_cnt == ADDR_W'(PIX_PER_LINE - 1));
  // At most one bank is full while idle, so a fixed preference is enough.
  assign pick    = ~bank_full[0];

  // Read FSM, address counter, one-cycle data-valid delay and line/frame pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_state   <= R_IDLE;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      line_idx   <= '0;
      data_valid <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_valid <= rd_en;
      line_done  <= rd_free;
      frame_done <= rd_free & (line_idx == LINE_W'(LINES_PER_FRAME - 1));
      case (rd_state)
        R_IDLE: begin
          if (|bank_full) begin
            rd_state <= R_RUN;
            rd_bank  <= pick;
            line_idx <= bank_line[pick];
            rd_cnt   <= '0;
          end
        end
        R_RUN: begin
          if (rd_free) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
          end else if (rd_en) begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: per-channel ping-pong line buffer sequencer (write FSM, bank status, errors).
// Optional macro LINE_BUF_OVERRUN_CNT_EN adds the DROP_CNT overrun counter output.
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE    = PIX_IN_ROW / NUMB_CHAN,
  parameter int unsigned LINES_PER_FRAME = LB_LINES_PER_FRAME,
  parameter int unsigned ADDR_W          = LB_ADDR_W,
  parameter int unsigned LINE_W          = LB_LINE_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FRAME_START,
  input  logic              LINE_START,
  input  logic              PIX_VALID,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              WR_BANK,
  input  logic              RD_READY,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_BANK,
  output logic              DATA_VALID,
  output logic [LINE_W-1:0] LINE_IDX,
  output logic              LINE_DONE,
  output logic              FRAME_DONE,
  output logic              OVERRUN,
  output logic              SHORT_LINE,
  input  logic              CLR_ERR
`ifdef LINE_BUF_OVERRUN_CNT_EN
  ,
  output logic [7:0]        DROP_CNT
`endif
);

  wr_state_t              wr_state;
  logic [ADDR_W-1:0]      wr_cnt;
  logic [LINE_W-1:0]      wr_line;
  logic [1:0]             bank_full;
  logic [1:0][LINE_W-1:0] bank_line;
  logic                   line_start_g;
  logic                   wr_last;
  logic                   other_free;
  logic                   line_sat;
  logic                   accept;
  logic                   overrun_set;
  logic                   short_set;
  logic                   rd_free;

  // Write strobe and line-completion decision; a bank freed this cycle counts as free.
  assign line_start_g = ENABLE & LINE_START;
  assign WR_EN        = (wr_state == W_FILL) & ENABLE & PIX_VALID & ~LINE_START & ~FRAME_START;
  assign WR_ADDR      = wr_cnt;
  assign wr_last      = WR_EN & (wr_cnt == ADDR_W'(PIX_PER_LINE - 1));
  assign other_free   = ~bank_full[~WR_BANK] | (rd_free & (RD_BANK == ~WR_BANK));
  assign line_sat     = (wr_line == LINE_W'(LINES_PER_FRAME));
  assign accept       = wr_last & ~line_sat & other_free;
  assign overrun_set  = wr_last & ~line_sat & ~other_free;
  assign short_set    = (wr_state == W_FILL) & line_start_g & ~FRAME_START & (wr_cnt != '0);

  // Write FSM, pixel counter, frame line counter and write bank.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_line  <= '0;
      WR_BANK  <= 1'b0;
    end else if (FRAME_START) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_line  <= '0;
    end else begin
      case (wr_state)
        W_IDLE, W_HOLD: begin
          if (line_start_g) begin
            wr_state <= W_FILL;
            wr_cnt   <= '0;
          end
        end
        W_FILL: begin
          if (line_start_g) begin
            wr_cnt <= '0;
          end else if (wr_last) begin
            wr_state <= W_HOLD;
            wr_cnt   <= '0;
            if (accept) begin
              WR_BANK <= ~WR_BANK;
              wr_line <= wr_line + LINE_W'(1);
            end
          end else if (WR_EN) begin
            wr_cnt <= wr_cnt + ADDR_W'(1);
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Bank status: set by an accepted line, cleared by the final read strobe (never the same bank).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bank_full <= '0;
      bank_line <= '0;
    end else begin
      if (accept) begin
        bank_full[WR_BANK] <= 1'b1;
        bank_line[WR_BANK] <= wr_line;
      end
      if (rd_free) begin
        bank_full[RD_BANK] <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERRUN    <= 1'b0;
      SHORT_LINE <= 1'b0;
    end else begin
      OVERRUN    <= overrun_set | (OVERRUN & ~CLR_ERR);
      SHORT_LINE <= short_set | (SHORT_LINE & ~CLR_ERR);
    end
  end

`ifdef LINE_BUF_OVERRUN_CNT_EN
  // Saturating per-frame count of lines lost to overrun; frame start clears first.
  always_ff @(posedge CLK) begin
    if (RESET || FRAME_START) begin
      DROP_CNT <= '0;
    end else if (overrun_set && (DROP_CNT != 8'hFF)) begin
      DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`endif

  line_buf_rd_seq #(
    .PIX_PER_LINE   (PIX_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME),
    .ADDR_W         (ADDR_W),
    .LINE_W         (LINE_W)
  ) u_rd_seq (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_ready  (RD_READY),
    .bank_full (bank_full),
    .bank_line (bank_line),
    .rd_en     (RD_EN),
    .rd_addr   (RD_ADDR),
    .rd_bank   (RD_BANK),
    .data_valid(DATA_VALID),
    .line_idx  (LINE_IDX),
    .line_done (LINE_DONE),
    .frame_done(FRAME_DONE),
    .rd_free   (rd_free)
  );

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed scenarios then random traffic, checked every cycle against a
// queue-based model of the ping-pong buffer.
module tb_line_buf_ctrl;

  localparam int unsigned PPL = 8;
  localparam int unsigned LPF = 4;
  localparam int unsigned AW  = 9;
  localparam int unsigned LW  = 9;

  logic          CLK = 1'b0;
  logic          RESET, ENABLE, FRAME_START, LINE_START, PIX_VALID, RD_READY, CLR_ERR;
  logic          WR_EN, WR_BANK, RD_EN, RD_BANK, DATA_VALID, LINE_DONE, FRAME_DONE;
  logic          OVERRUN, SHORT_LINE;
  logic [AW-1:0] WR_ADDR, RD_ADDR;
  logic [LW-1:0] LINE_IDX;
`ifdef LINE_BUF_OVERRUN_CNT_EN
  logic [7:0]    DROP_CNT;
`endif

  always #5 CLK = ~CLK;

  line_buf_ctrl #(
    .PIX_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .ADDR_W(AW), .LINE_W(LW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FRAME_START(FRAME_START),
    .LINE_START(LINE_START), .PIX_VALID(PIX_VALID), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_BANK(WR_BANK), .RD_READY(RD_READY), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .RD_BANK(RD_BANK), .DATA_VALID(DATA_VALID), .LINE_IDX(LINE_IDX), .LINE_DONE(LINE_DONE),
    .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .SHORT_LINE(SHORT_LINE), .CLR_ERR(CLR_ERR)
`ifdef LINE_BUF_OVERRUN_CNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );

  // Model: lines handed to the reader, oldest first; the head is the one being read.
  typedef struct { int bank; int idx; } rec_t;
  rec_t ready_q[$];
  int m_collect, m_wr_cnt, m_wr_line, m_wr_bank;
  int m_reading, m_rd_cnt, m_rd_bank, m_line_idx;
  int m_dv, m_ld, m_fd, m_ovr, m_shrt, m_drop;

  int checks = 0;
  int failures = 0;
  int n_ld = 0;
  int n_fd = 0;
  int fd_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bank_busy(input int b);
    foreach (ready_q[k]) if (ready_q[k].bank == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    ready_q.delete();
    m_collect = 0; m_wr_cnt = 0; m_wr_line = 0; m_wr_bank = 0;
    m_reading = 0; m_rd_cnt = 0; m_rd_bank = 0; m_line_idx = 0;
    m_dv = 0; m_ld = 0; m_fd = 0; m_ovr = 0; m_shrt = 0; m_drop = 0;
  endtask

  // Advance the model across one clock edge using the values present before the edge.
  task automatic model_step(input bit rst, input bit en, input bit fs, input bit ls,
                            input bit clr, input bit wr_en_e, input bit rd_en_e);
    bit rd_last, wr_last, ls_g, other_free, sat, accept, ovr, shrt;
    int other;
    if (rst) begin
      model_reset();
      return;
    end
    rd_last    = rd_en_e && (m_rd_cnt == PPL - 1);
    wr_last    = wr_en_e && (m_wr_cnt == PPL - 1);
    ls_g       = en && ls;
    other      = 1 - m_wr_bank;
    other_free = !bank_busy(other) || (rd_last && (m_rd_bank == other));
    sat        = (m_wr_line == LPF);
    accept     = wr_last && !sat && other_free;
    ovr        = wr_last && !sat && !other_free;
    shrt       = m_collect && ls_g && !fs && (m_wr_cnt != 0);
    m_ovr  = (ovr || (m_ovr && !clr)) ? 1 : 0;
    m_shrt = (shrt || (m_shrt && !clr)) ? 1 : 0;
    if (fs) m_drop = 0;
    else if (ovr && m_drop < 255) m_drop++;
    m_dv = rd_en_e;
    m_ld = rd_last;
    m_fd = (rd_last && (m_line_idx == LPF - 1)) ? 1 : 0;
    if (m_reading != 0) begin
      if (rd_last) begin
        void'(ready_q.pop_front());
        m_reading = 0;
        m_rd_cnt  = 0;
      end else if (rd_en_e) begin
        m_rd_cnt++;
      end
    end else if (ready_q.size() > 0) begin
      m_reading  = 1;
      m_rd_cnt   = 0;
      m_rd_bank  = ready_q[0].bank;
      m_line_idx = ready_q[0].idx;
    end
    if (fs) begin
      m_collect = 0; m_wr_cnt = 0; m_wr_line = 0;
    end else if (ls_g) begin
      m_collect = 1; m_wr_cnt = 0;
    end else if (wr_last) begin
      m_collect = 0; m_wr_cnt = 0;
      if (accept) begin
        ready_q.push_back('{m_wr_bank, m_wr_line});
        m_wr_bank = other;
        m_wr_line++;
      end
    end else if (wr_en_e) begin
      m_wr_cnt++;
    end
  endtask

  // One clock: drive, check strobes/addresses, clock, check registered outputs.
  task automatic cycle(input bit rst, input bit en, input bit fs, input bit ls,
                       input bit pv, input bit rdy, input bit clr);
    bit wr_en_e, rd_en_e;
    RESET = rst; ENABLE = en; FRAME_START = fs; LINE_START = ls;
    PIX_VALID = pv; RD_READY = rdy; CLR_ERR = clr;
    #1;
    wr_en_e = (m_collect != 0) && en && pv && !ls && !fs;
    rd_en_e = (m_reading != 0) && rdy;
    if (!rst) begin
      chk("wr_en",   32'(WR_EN),   32'(wr_en_e));
      chk("wr_addr", 32'(WR_ADDR), m_wr_cnt);
      chk("rd_en",   32'(RD_EN),   32'(rd_en_e));
      chk("rd_addr", 32'(RD_ADDR), m_rd_cnt);
    end
    @(posedge CLK);
    model_step(rst, en, fs, ls, clr, wr_en_e, rd_en_e);
    #1;
    chk("wr_bank",    32'(WR_BANK),    m_wr_bank);
    chk("rd_bank",    32'(RD_BANK),    m_rd_bank);
    chk("data_valid", 32'(DATA_VALID), m_dv);
    chk("line_idx",   32'(LINE_IDX),   m_line_idx);
    chk("line_done",  32'(LINE_DONE),  m_ld);
    chk("frame_done", 32'(FRAME_DONE), m_fd);
    chk("overrun",    32'(OVERRUN),    m_ovr);
    chk("short_line", 32'(SHORT_LINE), m_shrt);
`ifdef LINE_BUF_OVERRUN_CNT_EN
    chk("drop_cnt",   32'(DROP_CNT),   m_drop);
`endif
    if (LINE_DONE === 1'b1) n_ld++;
    if (FRAME_DONE === 1'b1) begin
      n_fd++;
      fd_idx = int'(LINE_IDX);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_line(input int npix, input bit rdy_ls, input bit rdy_pix);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rdy_ls, 1'b0);
    repeat (npix) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rdy_pix, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'(|{WR_EN, WR_ADDR, WR_BANK, RD_EN, RD_ADDR, RD_BANK, DATA_VALID,
                   LINE_IDX, LINE_DONE, FRAME_DONE, OVERRUN, SHORT_LINE}), 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset_zero");

    // Basic line: bank 0 written, swapped, read out as line 0
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("basic_wr_bank", 32'(WR_BANK), 32'd1);
    chk("basic_line_done_cnt", n_ld, 32'd1);
    chk("basic_line_idx", 32'(LINE_IDX), 32'd0);

    // Overrun: reader stalled, second full line dropped, then cleared
    send_line(8, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    chk("ovr_set", 32'(OVERRUN), 32'd1);
    chk("ovr_wr_bank", 32'(WR_BANK), 32'd0);
`ifdef LINE_BUF_OVERRUN_CNT_EN
    chk("ovr_drop_cnt", 32'(DROP_CNT), 32'd1);
`endif
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(OVERRUN), 32'd0);
    idle(12, 1'b1);
    chk("ovr_line_done_cnt", n_ld, 32'd2);

    // Short line: restart after 5 pixels, one line read out
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("short_set", 32'(SHORT_LINE), 32'd1);
    chk("short_line_done_cnt", n_ld, 32'd3);
    chk("short_wr_bank", 32'(WR_BANK), 32'd1);

    // Same-cycle free and swap
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("swap_pre_line_done_cnt", n_ld, 32'd4);
    send_line(8, 1'b0, 1'b0);
    idle(3, 1'b0);
    send_line(8, 1'b0, 1'b1);
    chk("swap_no_overrun", 32'(OVERRUN), 32'd0);
    chk("swap_wr_bank", 32'(WR_BANK), 32'd0);
    chk("swap_line_done_cnt", n_ld, 32'd5);
    idle(12, 1'b1);
    chk("swap_drain_cnt", n_ld, 32'd6);

    // Frame end: fourth accepted line, then a saturated fifth line
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("frame_done_cnt", n_fd, 32'd1);
    chk("frame_done_idx", fd_idx, 32'd3);
    chk("frame_line_done_cnt", n_ld, 32'd7);
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("sat_no_read", n_ld, 32'd7);
    chk("sat_no_overrun", 32'(OVERRUN), 32'd0);
    chk("sat_wr_bank", 32'(WR_BANK), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_line(8, 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("new_frame_line_done_cnt", n_ld, 32'd8);
    chk("new_frame_wr_bank", 32'(WR_BANK), 32'd0);

    // Reset in the middle of a read
    send_line(8, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all_zero("midread_reset_zero");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midread_no_rd_en", 32'(RD_EN), 32'd0);
    idle(5, 1'b1);
    chk("midread_no_line_done", n_ld, 32'd8);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 699) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 149) == 0), ($urandom_range(0, 13) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Single-clock sequencer for the per-channel ping-pong line buffer between the ADC capture path and the readout path.
- Generates write and read enables, addresses and bank selects, and owns the bank-swap decision.
- Tracks line and frame position; flags overrun and short-line errors.
- One instance per ADC channel; drives the line buffer's bank-select, write-enable and read-enable inputs.

Parameters:
- PIX_PER_LINE, default 160 (`PIX_IN_ROW/`NUMB_CHAN): pixels per line per channel.
- LINES_PER_FRAME, default 240: accepted lines per frame.
- ADDR_W, default 9: pixel address width; must satisfy 2^ADDR_W >= PIX_PER_LINE.
- LINE_W, default 9: line index width.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  write-side enable; when low, LINE_START and PIX_VALID are ignored.
- FRAME_START  in  1  one-cycle pulse at the start of a frame.
- LINE_START  in  1  one-cycle pulse at the start of a line.
- PIX_VALID  in  1  ADC sample valid this cycle.
- WR_EN  out  1  write strobe to the line buffer.
- WR_ADDR  out  ADDR_W  write address.
- WR_BANK  out  1  bank currently being written.
- RD_READY  in  1  downstream can accept a pixel.
- RD_EN  out  1  read strobe to the line buffer.
- RD_ADDR  out  ADDR_W  read address.
- RD_BANK  out  1  bank currently being read.
- DATA_VALID  out  1  buffer output valid; equals RD_EN delayed one cycle.
- LINE_IDX  out  LINE_W  frame line number of the line being read.
- LINE_DONE  out  1  pulse coincident with DATA_VALID of the last pixel of a line.
- FRAME_DONE  out  1  pulse coincident with LINE_DONE of line LINES_PER_FRAME-1.
- OVERRUN  out  1  sticky: a completed line was dropped.
- SHORT_LINE  out  1  sticky: LINE_START arrived mid-line.
- CLR_ERR  in  1  clears both sticky error bits.

Behaviour:
- Reset (synchronous, active-high): every output is 0, both banks free, FSMs idle, counters 0.
- Write FSM states: W_IDLE, W_FILL, W_HOLD.
- W_IDLE: on LINE_START with ENABLE high, go to W_FILL and set wr_cnt=0.
- W_FILL: each PIX_VALID asserts WR_EN combinationally from the registered state with WR_ADDR=wr_cnt; wr_cnt increments.
- Line completion is PIX_VALID with wr_cnt==PIX_PER_LINE-1; the FSM then moves to W_HOLD.
  - If the other bank is free, mark WR_BANK full, record the write line count as that bank's line index, toggle WR_BANK and increment the write line count.
  - Otherwise drop the line: the bank stays free and unchanged and OVERRUN is set.
- W_HOLD: PIX_VALID is ignored; LINE_START returns the FSM to W_FILL with wr_cnt=0.
- LINE_START while in W_FILL with wr_cnt!=0: the partial line is discarded, SHORT_LINE is set, wr_cnt=0, the bank is unchanged and the FSM stays in W_FILL.
- The write line count saturates at LINES_PER_FRAME; accepted lines beyond that are dropped without setting OVERRUN.
- FRAME_START zeroes the write line count and forces W_IDLE. It does not affect the read side.
- Read FSM states: R_IDLE, R_RUN.
- R_IDLE: when a full bank exists, set RD_BANK to it, rd_cnt=0, and go to R_RUN.
- R_RUN: RD_EN=RD_READY, RD_ADDR=rd_cnt, and rd_cnt increments on each RD_EN.
- The RD_EN at rd_cnt==PIX_PER_LINE-1 frees the bank and returns the FSM to R_IDLE.
- Freeing is visible to a write completion in the same cycle, so the swap succeeds with no OVERRUN.
- A bank is "not free" while full or being read. The write bank is therefore always free, and at most one bank waits.
- Read latency: pixel data appears at the line buffer output one cycle after RD_EN; DATA_VALID marks it.
- LINE_IDX holds the recorded line index of RD_BANK.
- CLR_ERR clears the sticky bits. If CLR_ERR and a new error occur in the same cycle, the set wins.
- Address counters never exceed PIX_PER_LINE-1; no wrap is visible on the ports.

Optional Feature:
- Macro: LINE_BUF_OVERRUN_CNT_EN.
- Defined: adds output DROP_CNT [7:0], a saturating count of lines dropped due to overrun in the current frame, cleared by FRAME_START or RESET. The FRAME_START clear takes priority over a same-cycle increment.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- define.v holds the shared constants: ADC_WIDHT, PIX_IN_ROW and NUMB_CHAN (existing), plus new LB_ADDR_W, LB_LINE_W and LB_LINES_PER_FRAME.
- The write and read FSM state encodings are localparams.
- Sub-module: line_buf_rd_seq, containing the read FSM, rd_cnt, the DATA_VALID delay, and the LINE_DONE/FRAME_DONE generation.
- The top level keeps the write FSM, the bank-status flags and the error bits.

Test Plan (PIX_PER_LINE=8, LINES_PER_FRAME=4):
- FRAME_START, LINE_START, 8 PIX_VALID, RD_READY=1 -> WR_ADDR 0..7 on bank 0; WR_BANK becomes 1; RD_EN 8 cycles with RD_ADDR 0..7 on RD_BANK 0; DATA_VALID one cycle later; LINE_DONE on the 8th DATA_VALID; LINE_IDX=0.
- RD_READY=0 and two full lines written -> the first line is held full and the second is dropped; OVERRUN=1; with the macro defined, DROP_CNT=1. CLR_ERR clears OVERRUN.
- LINE_START after 5 pixels -> SHORT_LINE=1; the next 8 pixels are written at WR_ADDR 0..7 on the same bank; exactly one line is read out.
- Last RD_EN of bank 0 in the same cycle as the 8th PIX_VALID of bank 1 -> no OVERRUN; WR_BANK returns to 0.
- Four accepted lines read out -> FRAME_DONE pulses with the 4th LINE_DONE and LINE_IDX=3; a 5th line is dropped without OVERRUN until FRAME_START.
- RESET asserted mid-line during a read -> next cycle all outputs are 0, both banks free, and no stale RD_EN.
